// File: rtl/cache_generator_request_multi.sv
// Multi-channel request front end for a cache: round-robin arbiter, one-entry
// staging register that drops MEM_RESPONSE packets, and a first-word-fall-through FIFO.
module cache_generator_request_multi #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 32,
    parameter int META_W      = 32,
    parameter int FIFO_DEPTH  = 16,
    parameter int PROG_THRESH = 8,
    localparam int SRC_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1,
    localparam int STRB_W     = DATA_W / 8
) (
    input  logic                        ap_clk,
    input  logic                        areset,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [2*NUM_REQ-1:0]        req_cmd,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_base,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_offset,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ*META_W-1:0]   req_meta,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ADDR_W-1:0]           out_addr,
    output logic [DATA_W-1:0]           out_wdata,
    output logic [STRB_W-1:0]           out_wstrb,
    output logic [META_W-1:0]           out_meta,
    output logic [SRC_W-1:0]            out_src,
    output logic [CNT_W-1:0]            fifo_count,
    output logic                        full,
    output logic                        empty,
    output logic                        prog_full,
    output logic [15:0]                 drop_count
);

    typedef enum logic [1:0] {
        CMD_READ         = 2'd0,
        CMD_WRITE        = 2'd1,
        CMD_MEM_RESPONSE = 2'd2,
        CMD_RESERVED     = 2'd3
    } cmd_e;

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = ADDR_W + DATA_W + STRB_W + META_W + SRC_W;

    // Per-channel views of the packed request buses
    logic [1:0]        ch_cmd  [NUM_REQ];
    logic [ADDR_W-1:0] ch_addr [NUM_REQ];
    logic [DATA_W-1:0] ch_data [NUM_REQ];
    logic [META_W-1:0] ch_meta [NUM_REQ];

    logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              grant_found;
    logic [SRC_W-1:0]  grant_idx;
    int                cand;

    logic              stage_valid_q, stage_valid_d;
    cmd_e              stage_cmd_q;
    logic [ADDR_W-1:0] stage_addr_q;
    logic [DATA_W-1:0] stage_wdata_q;
    logic [STRB_W-1:0] stage_wstrb_q;
    logic [META_W-1:0] stage_meta_q;
    logic [SRC_W-1:0]  stage_src_q;
    logic [ENTRY_W-1:0] stage_entry;

    logic              stage_drain, stage_ready, accept, push, pop, drop;

    logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              prog_full_q, prog_full_d;
    logic [15:0]       drop_q, drop_d;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ch
            assign ch_cmd[gi]    = req_cmd[gi*2 +: 2];
            assign ch_addr[gi]   = req_base[gi*ADDR_W +: ADDR_W] + req_offset[gi*ADDR_W +: ADDR_W];
            assign ch_data[gi]   = req_data[gi*DATA_W +: DATA_W];
            assign ch_meta[gi]   = req_meta[gi*META_W +: META_W];
            assign req_ready[gi] = accept && (grant_idx == SRC_W'(gi));
        end
    endgenerate

    // Round-robin search starting at rr_ptr, wrapping past the last channel
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(rr_ptr_q) + i) % NUM_REQ;
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = SRC_W'(cand);
            end
        end
    end

    // A staged MEM_RESPONSE always leaves; anything else leaves only into a non-full FIFO
    assign stage_drain = stage_valid_q && ((stage_cmd_q == CMD_MEM_RESPONSE) || !full_q);
    assign stage_ready = !stage_valid_q || stage_drain;
    assign accept      = grant_found && stage_ready && !areset;
    assign push        = stage_valid_q && (stage_cmd_q != CMD_MEM_RESPONSE) && !full_q && !areset;
    assign drop        = stage_valid_q && (stage_cmd_q == CMD_MEM_RESPONSE) && !areset;
    assign out_valid   = !empty_q && !areset;
    assign pop         = out_valid && out_ready;

    assign stage_entry = {stage_addr_q, stage_wdata_q, stage_wstrb_q, stage_meta_q, stage_src_q};

    always_comb begin
        rr_ptr_d      = rr_ptr_q;
        stage_valid_d = stage_valid_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        drop_d        = drop_q;

        if (accept) begin
            rr_ptr_d      = (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + SRC_W'(1);
            stage_valid_d = 1'b1;
        end else if (stage_drain) begin
            stage_valid_d = 1'b0;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (drop && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end

        full_d      = (count_d == CNT_W'(FIFO_DEPTH));
        empty_d     = (count_d == '0);
        prog_full_d = (count_d >= CNT_W'(PROG_THRESH));
    end

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            rr_ptr_q      <= '0;
            stage_valid_q <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
            prog_full_q   <= 1'b0;
            drop_q        <= '0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            stage_valid_q <= stage_valid_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            full_q        <= full_d;
            empty_q       <= empty_d;
            prog_full_q   <= prog_full_d;
            drop_q        <= drop_d;
        end
    end

    // Payload registers carry no reset; stage_valid_q qualifies them
    always_ff @(posedge ap_clk) begin
        if (accept) begin
            stage_cmd_q   <= cmd_e'(ch_cmd[grant_idx]);
            stage_addr_q  <= ch_addr[grant_idx];
            stage_wdata_q <= ch_data[grant_idx];
            stage_wstrb_q <= (ch_cmd[grant_idx] == CMD_WRITE) ? '1 : '0;
            stage_meta_q  <= ch_meta[grant_idx];
            stage_src_q   <= grant_idx;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= stage_entry;
        end
    end

    assign {out_addr, out_wdata, out_wstrb, out_meta, out_src} = mem_q[rd_ptr_q];

    assign fifo_count = count_q;
    assign full       = full_q;
    assign empty      = empty_q;
    assign prog_full  = prog_full_q;
    assign drop_count = drop_q;

endmodule
